// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: ROB sizing, the ROB-to-BTB update packet and
// the per-ROB-slot branch training record.
package rv32i_types;

  localparam int unsigned ROB_DEPTH         = 16;
  localparam int unsigned ROB_IDX_BITS      = 4;
  localparam int unsigned GSHARE_DEPTH_BITS = 10;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  pred_branch_address;
    logic                         branch_inst;
    logic                         jal_inst;
    logic                         branch_resol;
    logic                         branch_update;
    logic [GSHARE_DEPTH_BITS-1:0] gshare_index;
    logic                         ready;
    logic                         valid;
  } rob_to_btb_bus;

  typedef struct packed {
    logic                         alloc;
    logic                         resolved;
    logic                         is_branch;
    logic                         is_jal;
    logic [31:0]                  pc;
    logic                         pred_taken;
    logic [31:0]                  pred_target;
    logic [GSHARE_DEPTH_BITS-1:0] gshare_index;
    logic                         act_taken;
    logic [31:0]                  act_target;
  } btb_commit_entry_t;

  // Wrong direction, or right direction (taken) with a wrong target.
  function automatic logic is_mispredict(input btb_commit_entry_t e);
    return (e.pred_taken != e.act_taken) ||
           (e.act_taken && (e.pred_target != e.act_target));
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/btb_commit_update_gen.sv
// Collects dispatch-time predictions and out-of-order resolutions per ROB slot,
// then emits one predictor update packet (and any mispredict flush) per commit.
module btb_commit_update_gen
  import rv32i_types::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_valid,
  input  logic [ROB_IDX_BITS-1:0]      disp_rob_id,
  input  logic [31:0]                  disp_pc,
  input  logic                         disp_is_branch,
  input  logic                         disp_is_jal,
  input  logic                         disp_pred_taken,
  input  logic [31:0]                  disp_pred_target,
  input  logic [GSHARE_DEPTH_BITS-1:0] disp_gshare_index,
  input  logic                         res_valid,
  input  logic [ROB_IDX_BITS-1:0]      res_rob_id,
  input  logic                         res_taken,
  input  logic [31:0]                  res_target,
  input  logic                         commit_valid,
  input  logic [ROB_IDX_BITS-1:0]      commit_rob_id,
  output logic                         commit_ready,
  input  logic                         flush_i,
  output rob_to_btb_bus                upd_o,
  output logic                         flush_o,
  output logic [31:0]                  flush_pc_o,
  output logic [31:0]                  branch_count_o,
  output logic [31:0]                  mispredict_count_o
);

  btb_commit_entry_t entries [ROB_DEPTH];
  btb_commit_entry_t head;
  logic              commit_fire;
  logic              commit_mis;
  logic              res_ok;

  always_comb begin
    head         = entries[commit_rob_id];
    commit_fire  = commit_valid && head.alloc && head.resolved;
    commit_mis   = commit_fire && is_mispredict(head);
    commit_ready = !(commit_valid && head.alloc && !head.resolved);
    // Dispatch to the same slot wins; a slot freed by this cycle's commit stays free.
    res_ok = res_valid && entries[res_rob_id].alloc &&
             !(disp_valid && (disp_rob_id == res_rob_id)) &&
             !(commit_fire && (commit_rob_id == res_rob_id));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries[i].alloc    <= 1'b0;
        entries[i].resolved <= 1'b0;
      end
      upd_o      <= '0;
      flush_o    <= 1'b0;
      flush_pc_o <= '0;
    end else begin
      upd_o   <= '0;
      flush_o <= 1'b0;

      if (commit_fire) begin
        upd_o.valid               <= 1'b1;
        upd_o.ready               <= 1'b1;
        upd_o.pc                  <= head.pc;
        upd_o.pred_branch_address <= head.act_target;
        upd_o.branch_inst         <= head.is_branch;
        upd_o.jal_inst            <= head.is_jal;
        upd_o.branch_resol        <= head.act_taken;
        upd_o.branch_update       <= head.act_taken;
        upd_o.gshare_index        <= head.gshare_index;
        flush_o                   <= commit_mis;
        if (commit_mis) begin
          flush_pc_o <= head.act_taken ? head.act_target : head.pc + 32'd4;
        end
        entries[commit_rob_id].alloc    <= 1'b0;
        entries[commit_rob_id].resolved <= 1'b0;
      end

      // Flush clears every slot after the commit above has been captured.
      if (flush_i) begin
        for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
          entries[i].alloc    <= 1'b0;
          entries[i].resolved <= 1'b0;
        end
      end else begin
        if (res_ok) begin
          entries[res_rob_id].resolved   <= 1'b1;
          entries[res_rob_id].act_taken  <= res_taken || entries[res_rob_id].is_jal;
          entries[res_rob_id].act_target <= res_target;
        end
        if (disp_valid) begin
          assert (!entries[disp_rob_id].alloc ||
                  (commit_fire && (commit_rob_id == disp_rob_id)));
          entries[disp_rob_id].alloc        <= 1'b1;
          entries[disp_rob_id].resolved     <= 1'b0;
          entries[disp_rob_id].is_branch    <= disp_is_branch;
          entries[disp_rob_id].is_jal       <= disp_is_jal;
          entries[disp_rob_id].pc           <= disp_pc;
          entries[disp_rob_id].pred_taken   <= disp_pred_taken;
          entries[disp_rob_id].pred_target  <= disp_pred_target;
          entries[disp_rob_id].gshare_index <= disp_gshare_index;
          entries[disp_rob_id].act_taken    <= 1'b0;
          entries[disp_rob_id].act_target   <= '0;
        end
      end
    end
  end

  sat_counter32 u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (commit_fire),
    .count (branch_count_o)
  );

  sat_counter32 u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (commit_mis),
    .count (mispredict_count_o)
  );

endmodule

// File: tb/tb_btb_commit_update_gen.sv
// Directed bench for btb_commit_update_gen: hand-computed packets, flushes and counts.
module tb_btb_commit_update_gen;
  import rv32i_types::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         disp_valid;
  logic [ROB_IDX_BITS-1:0]      disp_rob_id;
  logic [31:0]                  disp_pc;
  logic                         disp_is_branch;
  logic                         disp_is_jal;
  logic                         disp_pred_taken;
  logic [31:0]                  disp_pred_target;
  logic [GSHARE_DEPTH_BITS-1:0] disp_gshare_index;
  logic                         res_valid;
  logic [ROB_IDX_BITS-1:0]      res_rob_id;
  logic                         res_taken;
  logic [31:0]                  res_target;
  logic                         commit_valid;
  logic [ROB_IDX_BITS-1:0]      commit_rob_id;
  logic                         commit_ready;
  logic                         flush_i;
  rob_to_btb_bus                upd_o;
  logic                         flush_o;
  logic [31:0]                  flush_pc_o;
  logic [31:0]                  branch_count_o;
  logic [31:0]                  mispredict_count_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  btb_commit_update_gen dut (
    .clk                (clk),
    .rst                (rst),
    .disp_valid         (disp_valid),
    .disp_rob_id        (disp_rob_id),
    .disp_pc            (disp_pc),
    .disp_is_branch     (disp_is_branch),
    .disp_is_jal        (disp_is_jal),
    .disp_pred_taken    (disp_pred_taken),
    .disp_pred_target   (disp_pred_target),
    .disp_gshare_index  (disp_gshare_index),
    .res_valid          (res_valid),
    .res_rob_id         (res_rob_id),
    .res_taken          (res_taken),
    .res_target         (res_target),
    .commit_valid       (commit_valid),
    .commit_rob_id      (commit_rob_id),
    .commit_ready       (commit_ready),
    .flush_i            (flush_i),
    .upd_o              (upd_o),
    .flush_o            (flush_o),
    .flush_pc_o         (flush_pc_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [3:0] id, input logic [31:0] pc, input logic br,
                      input logic jal, input logic pt, input logic [31:0] ptgt,
                      input logic [9:0] gidx);
    disp_valid = 1'b1; disp_rob_id = id; disp_pc = pc; disp_is_branch = br;
    disp_is_jal = jal; disp_pred_taken = pt; disp_pred_target = ptgt;
    disp_gshare_index = gidx;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic resolve(input logic [3:0] id, input logic t, input logic [31:0] tgt);
    res_valid = 1'b1; res_rob_id = id; res_taken = t; res_target = tgt;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id);
    commit_valid = 1'b1; commit_rob_id = id;
    tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; disp_valid = 1'b0; disp_rob_id = '0; disp_pc = '0;
    disp_is_branch = 1'b0; disp_is_jal = 1'b0; disp_pred_taken = 1'b0;
    disp_pred_target = '0; disp_gshare_index = '0; res_valid = 1'b0;
    res_rob_id = '0; res_taken = 1'b0; res_target = '0; commit_valid = 1'b0;
    commit_rob_id = '0; flush_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, upd_o.valid}, 32'd0);
    chk("rst_upd_all", upd_o[31:0], 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_flush_pc", flush_pc_o, 32'd0);
    chk("rst_bcnt", branch_count_o, 32'd0);
    chk("rst_mcnt", mispredict_count_o, 32'd0);

    // Correctly predicted not-taken branch
    disp(4'd3, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104, 10'h2A);
    resolve(4'd3, 1'b0, 32'h200);
    commit_valid = 1'b1; commit_rob_id = 4'd3; #1;
    chk("t1_ready", {31'd0, commit_ready}, 32'd1);
    tick(); commit_valid = 1'b0;
    chk("t1_valid", {31'd0, upd_o.valid}, 32'd1);
    chk("t1_ready_fld", {31'd0, upd_o.ready}, 32'd1);
    chk("t1_pc", upd_o.pc, 32'h100);
    chk("t1_addr", upd_o.pred_branch_address, 32'h200);
    chk("t1_binst", {31'd0, upd_o.branch_inst}, 32'd1);
    chk("t1_bupd", {31'd0, upd_o.branch_update}, 32'd0);
    chk("t1_gidx", {22'd0, upd_o.gshare_index}, 32'h2A);
    chk("t1_flush", {31'd0, flush_o}, 32'd0);
    chk("t1_bcnt", branch_count_o, 32'd1);
    tick();
    chk("t1_oneshot", {31'd0, upd_o.valid}, 32'd0);

    // Predicted NT, actually taken -> flush to target
    disp(4'd3, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104, 10'h2A);
    resolve(4'd3, 1'b1, 32'h200);
    commit(4'd3);
    chk("t2_valid", {31'd0, upd_o.valid}, 32'd1);
    chk("t2_bupd", {31'd0, upd_o.branch_update}, 32'd1);
    chk("t2_flush", {31'd0, flush_o}, 32'd1);
    chk("t2_flush_pc", flush_pc_o, 32'h200);
    chk("t2_mcnt", mispredict_count_o, 32'd1);
    tick();
    chk("t2_flush_pulse", {31'd0, flush_o}, 32'd0);

    // jal with wrong target; resolve direction forced taken
    disp(4'd5, 32'h300, 1'b0, 1'b1, 1'b1, 32'h400, 10'h011);
    resolve(4'd5, 1'b0, 32'h404);
    commit(4'd5);
    chk("t3_jal", {31'd0, upd_o.jal_inst}, 32'd1);
    chk("t3_binst", {31'd0, upd_o.branch_inst}, 32'd0);
    chk("t3_bupd", {31'd0, upd_o.branch_update}, 32'd1);
    chk("t3_flush", {31'd0, flush_o}, 32'd1);
    chk("t3_flush_pc", flush_pc_o, 32'h404);
    chk("t3_bcnt", branch_count_o, 32'd3);
    chk("t3_mcnt", mispredict_count_o, 32'd2);

    // Commit stalls on an unresolved head
    disp(4'd7, 32'h500, 1'b1, 1'b0, 1'b1, 32'h600, 10'h3FF);
    commit_valid = 1'b1; commit_rob_id = 4'd7; #1;
    chk("t4_stall", {31'd0, commit_ready}, 32'd0);
    tick();
    chk("t4_no_pkt", {31'd0, upd_o.valid}, 32'd0);
    res_valid = 1'b1; res_rob_id = 4'd7; res_taken = 1'b1; res_target = 32'h600; #1;
    chk("t4_stall_res", {31'd0, commit_ready}, 32'd0);
    tick(); res_valid = 1'b0; #1;
    chk("t4_go", {31'd0, commit_ready}, 32'd1);
    chk("t4_no_pkt2", {31'd0, upd_o.valid}, 32'd0);
    tick(); commit_valid = 1'b0;
    chk("t4_valid", {31'd0, upd_o.valid}, 32'd1);
    chk("t4_pc", upd_o.pc, 32'h500);
    chk("t4_gidx", {22'd0, upd_o.gshare_index}, 32'h3FF);
    chk("t4_flush", {31'd0, flush_o}, 32'd0);
    chk("t4_bcnt", branch_count_o, 32'd4);

    // Out-of-order resolution, in-order back-to-back commit
    disp(4'd0, 32'h10, 1'b1, 1'b0, 1'b0, 32'h14, 10'h001);
    disp(4'd1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h80, 10'h002);
    resolve(4'd1, 1'b1, 32'h80);
    resolve(4'd0, 1'b0, 32'h30);
    commit_valid = 1'b1; commit_rob_id = 4'd0;
    tick();
    commit_rob_id = 4'd1;
    chk("t5_pkt0_v", {31'd0, upd_o.valid}, 32'd1);
    chk("t5_pkt0_pc", upd_o.pc, 32'h10);
    tick(); commit_valid = 1'b0;
    chk("t5_pkt1_v", {31'd0, upd_o.valid}, 32'd1);
    chk("t5_pkt1_pc", upd_o.pc, 32'h20);
    chk("t5_pkt1_flush", {31'd0, flush_o}, 32'd0);
    tick();
    chk("t5_idle", {31'd0, upd_o.valid}, 32'd0);
    chk("t5_bcnt", branch_count_o, 32'd6);
    chk("t5_mcnt", mispredict_count_o, 32'd2);

    // Resolve to a free slot is ignored; a non-control commit is a no-op
    resolve(4'd9, 1'b1, 32'h999);
    commit_valid = 1'b1; commit_rob_id = 4'd9; #1;
    chk("t6_free_ready", {31'd0, commit_ready}, 32'd1);
    tick(); commit_valid = 1'b0;
    chk("t6_free_nopkt", {31'd0, upd_o.valid}, 32'd0);

    // Same-cycle dispatch and resolve: resolve dropped
    disp_valid = 1'b1; disp_rob_id = 4'd6; disp_pc = 32'hA00; disp_is_branch = 1'b1;
    disp_is_jal = 1'b0; disp_pred_taken = 1'b0; disp_pred_target = 32'hA04;
    disp_gshare_index = 10'h055;
    res_valid = 1'b1; res_rob_id = 4'd6; res_taken = 1'b0; res_target = 32'hA04;
    tick(); disp_valid = 1'b0; res_valid = 1'b0;
    commit_valid = 1'b1; commit_rob_id = 4'd6; #1;
    chk("t6_drop_res", {31'd0, commit_ready}, 32'd0);
    commit_valid = 1'b0;
    resolve(4'd6, 1'b0, 32'hA04);
    commit(4'd6);
    chk("t6_pkt_pc", upd_o.pc, 32'hA00);
    chk("t6_bcnt", branch_count_o, 32'd7);

    // flush_i with a same-cycle commit of slot 2; slot 4 is discarded
    disp(4'd2, 32'h700, 1'b1, 1'b0, 1'b0, 32'h704, 10'h0F0);
    disp(4'd4, 32'h800, 1'b1, 1'b0, 1'b0, 32'h804, 10'h0F1);
    resolve(4'd2, 1'b1, 32'h900);
    resolve(4'd4, 1'b0, 32'h808);
    flush_i = 1'b1; commit_valid = 1'b1; commit_rob_id = 4'd2;
    tick(); flush_i = 1'b0; commit_valid = 1'b0;
    chk("t7_pkt_v", {31'd0, upd_o.valid}, 32'd1);
    chk("t7_pkt_pc", upd_o.pc, 32'h700);
    chk("t7_flush", {31'd0, flush_o}, 32'd1);
    chk("t7_flush_pc", flush_pc_o, 32'h900);
    commit_valid = 1'b1; commit_rob_id = 4'd4; #1;
    chk("t7_slot4_ready", {31'd0, commit_ready}, 32'd1);
    tick(); commit_valid = 1'b0;
    chk("t7_slot4_nopkt", {31'd0, upd_o.valid}, 32'd0);
    chk("t7_bcnt", branch_count_o, 32'd8);
    chk("t7_mcnt", mispredict_count_o, 32'd3);

    // Predicted taken, actually not taken at top of address space: pc+4 wraps
    disp(4'd8, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h40, 10'h000);
    resolve(4'd8, 1'b0, 32'h40);
    commit(4'd8);
    chk("t8_flush", {31'd0, flush_o}, 32'd1);
    chk("t8_flush_pc", flush_pc_o, 32'h0);
    chk("t8_mcnt", mispredict_count_o, 32'd4);

    // Reset concurrent with a mispredicting commit suppresses everything
    disp(4'd10, 32'hB00, 1'b1, 1'b0, 1'b0, 32'hB04, 10'h0AA);
    resolve(4'd10, 1'b1, 32'hC00);
    rst = 1'b1; commit_valid = 1'b1; commit_rob_id = 4'd10;
    tick(); rst = 1'b0; commit_valid = 1'b0;
    chk("t9_nopkt", {31'd0, upd_o.valid}, 32'd0);
    chk("t9_noflush", {31'd0, flush_o}, 32'd0);
    chk("t9_flush_pc", flush_pc_o, 32'd0);
    chk("t9_bcnt", branch_count_o, 32'd0);
    chk("t9_mcnt", mispredict_count_o, 32'd0);
    commit(4'd10);
    chk("t9_freed", {31'd0, upd_o.valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
